// File: rtl/hpi_responder_if.sv
// Local-side port bundle for hpi_responder: memory write port, outbound mailbox load, inbound mailbox handshake.
// Latency: n/a (wiring only).
// Backpressure: none; the inbound mailbox uses a valid/ack pair, and the responder overwrites unacked data.
interface hpi_responder_if #(
    parameter int AW = 8
);
    logic          loc_we;
    logic [AW-1:0] loc_addr;
    logic [15:0]   loc_wdata;
    logic          loc_mbx_wr;
    logic [15:0]   loc_mbx_data;
    logic          mbx_in_valid;
    logic [15:0]   mbx_in_data;
    logic          mbx_in_ack;

    modport master (
        output loc_we, loc_addr, loc_wdata, loc_mbx_wr, loc_mbx_data, mbx_in_ack,
        input  mbx_in_valid, mbx_in_data
    );

    modport slave (
        input  loc_we, loc_addr, loc_wdata, loc_mbx_wr, loc_mbx_data, mbx_in_ack,
        output mbx_in_valid, mbx_in_data
    );
endinterface

// File: rtl/hpi_responder.sv
// HPI host-port slave: word memory, ADDRESS/STATUS registers, in/out mailboxes; HPI_RESP_AUTOINC_EN adds ADDRESS+=2 per DATA access.
// Latency: host pins pass 2-flop syncs; read data driven from the 2nd RD_ACTIVE cycle; writes commit 1 cycle after synced WR_N rises.
// Backpressure: none; an unacked inbound mailbox is overwritten and the sticky overrun flag is raised.
module hpi_responder #(
    parameter int MEM_WORDS = 256
) (
    input  logic           Clk,
    input  logic           Reset,
    inout  wire  [15:0]    OTG_DATA,
    input  logic [1:0]     OTG_ADDR,
    input  logic           OTG_CS_N,
    input  logic           OTG_RD_N,
    input  logic           OTG_WR_N,
    input  logic           OTG_RST_N,
    output logic           OTG_INT,
    hpi_responder_if.slave loc
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] REG_DATA = 2'b00;
    localparam logic [1:0] REG_MBX  = 2'b01;
    localparam logic [1:0] REG_ADDR = 2'b10;
    localparam logic [1:0] REG_STAT = 2'b11;

    typedef enum logic [1:0] {IDLE, RD_ACTIVE, WR_ACTIVE, WR_COMMIT} state_t;

    logic [21:0] sync_meta_q, sync_q;
    logic        rst_n_s, cs_n_s, rd_n_s, wr_n_s;
    logic [1:0]  addr_s;
    logic [15:0] data_s;
    logic        rst_all;

    state_t      state_q;
    logic [1:0]  sel_q;
    logic [15:0] wr_dat_q, rd_dat_q;
    logic        oe_q, rd_ph_q, armed_q;

    logic [15:0] addr_d, addr_q, mbx_out_d, mbx_out_q, mbx_in_dat_d, mbx_in_dat_q;
    logic        int_d, int_q, mbx_in_vld_d, mbx_in_vld_q, ovr_d, ovr_q, loc_seen_d, loc_seen_q;
    logic        rd_exit, commit;
    logic [AW-1:0] word_idx;
    logic [15:0] status, rd_mux;

    logic [15:0] mem [MEM_WORDS];

    // Two-flop synchronizers on every host pin; left unreset so they keep tracking the pins through Reset.
    always_ff @(posedge Clk) begin
        sync_meta_q <= {OTG_RST_N, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_ADDR, OTG_DATA};
        sync_q      <= sync_meta_q;
    end

    assign rst_n_s  = sync_q[21];
    assign cs_n_s   = sync_q[20];
    assign rd_n_s   = sync_q[19];
    assign wr_n_s   = sync_q[18];
    assign addr_s   = sync_q[17:16];
    assign data_s   = sync_q[15:0];
    assign rst_all  = Reset | ~rst_n_s;

    assign rd_exit  = (state_q == RD_ACTIVE) && (rd_n_s || cs_n_s);
    assign commit   = (state_q == WR_COMMIT);
    assign word_idx = addr_q[AW:1];
    assign status   = {13'd0, ovr_q, mbx_in_vld_q, int_q};

    // Register selected for the current read; sel_q is frozen at transaction start.
    always_comb begin
        case (sel_q)
            REG_DATA: rd_mux = mem[word_idx];
            REG_MBX:  rd_mux = mbx_out_q;
            REG_ADDR: rd_mux = addr_q;
            default:  rd_mux = status;
        endcase
    end

    // Host bus FSM; armed_q blocks new transactions after reset until CS_N has been seen high.
    always_ff @(posedge Clk) begin
        if (rst_all) begin
            state_q  <= IDLE;
            sel_q    <= 2'b00;
            wr_dat_q <= 16'd0;
            rd_dat_q <= 16'd0;
            oe_q     <= 1'b0;
            rd_ph_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    oe_q    <= 1'b0;
                    rd_ph_q <= 1'b0;
                    if (cs_n_s) begin
                        armed_q <= 1'b1;
                    end
                    if (armed_q && !cs_n_s && !wr_n_s) begin
                        state_q <= WR_ACTIVE;
                        sel_q   <= addr_s;
                    end else if (armed_q && !cs_n_s && !rd_n_s) begin
                        state_q <= RD_ACTIVE;
                        sel_q   <= addr_s;
                    end
                end
                RD_ACTIVE: begin
                    if (rd_n_s || cs_n_s) begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                    end else if (!rd_ph_q) begin
                        rd_ph_q  <= 1'b1;
                        rd_dat_q <= rd_mux;
                        oe_q     <= 1'b1;
                    end
                end
                WR_ACTIVE: begin
                    wr_dat_q <= data_s;
                    if (wr_n_s) begin
                        state_q <= WR_COMMIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign OTG_DATA = oe_q ? rd_dat_q : 16'hzzzz;

    // Next-state for ADDRESS, mailboxes, interrupt and overrun, driven by FSM events and the local side.
    always_comb begin
        addr_d       = addr_q;
        mbx_out_d    = mbx_out_q;
        int_d        = int_q;
        mbx_in_vld_d = mbx_in_vld_q;
        mbx_in_dat_d = mbx_in_dat_q;
        ovr_d        = ovr_q;
        loc_seen_d   = (state_q == RD_ACTIVE) && (loc_seen_q || loc.loc_mbx_wr);

        if (commit && sel_q == REG_ADDR) begin
            addr_d = wr_dat_q;
        end
`ifdef HPI_RESP_AUTOINC_EN
        if ((commit || rd_exit) && sel_q == REG_DATA) begin
            addr_d = addr_q + 16'd2;
        end
`endif

        // A local load during the read keeps the interrupt up with the fresh value.
        if (rd_exit && sel_q == REG_MBX && !loc_seen_q) begin
            int_d = 1'b0;
        end
        if (loc.loc_mbx_wr) begin
            mbx_out_d = loc.loc_mbx_data;
            int_d     = 1'b1;
        end

        // Ack and host write in the same cycle: the new word stays valid, no overrun.
        if (loc.mbx_in_ack) begin
            mbx_in_vld_d = 1'b0;
        end
        if (commit && sel_q == REG_MBX) begin
            mbx_in_vld_d = 1'b1;
            mbx_in_dat_d = wr_dat_q;
            if (mbx_in_vld_q && !loc.mbx_in_ack) begin
                ovr_d = 1'b1;
            end
        end
        if (rd_exit && sel_q == REG_STAT) begin
            ovr_d = 1'b0;
        end
    end

    // Register state with synchronous reset (Reset pin or synced OTG_RST_N).
    always_ff @(posedge Clk) begin
        if (rst_all) begin
            addr_q       <= 16'd0;
            mbx_out_q    <= 16'd0;
            int_q        <= 1'b0;
            mbx_in_vld_q <= 1'b0;
            mbx_in_dat_q <= 16'd0;
            ovr_q        <= 1'b0;
            loc_seen_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            mbx_out_q    <= mbx_out_d;
            int_q        <= int_d;
            mbx_in_vld_q <= mbx_in_vld_d;
            mbx_in_dat_q <= mbx_in_dat_d;
            ovr_q        <= ovr_d;
            loc_seen_q   <= loc_seen_d;
        end
    end

    // Memory is never reset; the host write is issued last so it wins a same-word collision.
    always_ff @(posedge Clk) begin
        if (loc.loc_we) begin
            mem[loc.loc_addr] <= loc.loc_wdata;
        end
        if (commit && sel_q == REG_DATA && !rst_all) begin
            mem[word_idx] <= wr_dat_q;
        end
    end

    assign OTG_INT          = int_q;
    assign loc.mbx_in_valid = mbx_in_vld_q;
    assign loc.mbx_in_data  = mbx_in_dat_q;
endmodule

// File: tb/tb_hpi_responder.sv
// Bench for hpi_responder: directed scenarios plus randomized host/local traffic against a register-level model.
// Latency: host cycles are paced generously so every access completes before the next.
// Backpressure: mailbox acks are issued explicitly by the bench.
module tb_hpi_responder;
    localparam int MEM_WORDS = 64;
    localparam int AW = $clog2(MEM_WORDS);
`ifdef HPI_RESP_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam logic [1:0] R_DATA = 2'b00, R_MBX = 2'b01, R_ADDR = 2'b10, R_STAT = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  otg_addr;
    logic        cs_n, rd_n, wr_n, otg_rst_n;
    logic        otg_int;
    wire  [15:0] otg_data;
    logic        tb_oe;
    logic [15:0] tb_dat;

    always #5 clk = ~clk;

    assign otg_data = tb_oe ? tb_dat : 16'hzzzz;

    hpi_responder_if #(.AW(AW)) lif ();

    hpi_responder #(.MEM_WORDS(MEM_WORDS)) dut (
        .Clk       (clk),
        .Reset     (rst),
        .OTG_DATA  (otg_data),
        .OTG_ADDR  (otg_addr),
        .OTG_CS_N  (cs_n),
        .OTG_RD_N  (rd_n),
        .OTG_WR_N  (wr_n),
        .OTG_RST_N (otg_rst_n),
        .OTG_INT   (otg_int),
        .loc       (lif)
    );

    // Reference model: the visible register file of the responder.
    logic [15:0] m_mem [MEM_WORDS];
    logic [15:0] m_addr, m_out, m_in_dat;
    bit          m_int, m_in_vld, m_ovr;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % MEM_WORDS;
    endfunction

    function automatic logic [15:0] m_read(input logic [1:0] r);
        case (r)
            R_DATA:  return m_mem[widx(m_addr)];
            R_MBX:   return m_out;
            R_ADDR:  return m_addr;
            default: return {13'd0, m_ovr, m_in_vld, m_int};
        endcase
    endfunction

    task automatic model_reset();
        m_addr = 16'd0; m_out = 16'd0; m_in_dat = 16'd0;
        m_int = 1'b0; m_in_vld = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_side(input string tag);
        check({tag, "_int"}, otg_int, m_int);
        check({tag, "_vld"}, lif.mbx_in_valid, m_in_vld);
        check({tag, "_idat"}, lif.mbx_in_data, m_in_dat);
    endtask

    // mode 0: plain; 1: loc_we lands in the commit cycle; 2: mbx_in_ack lands in the commit cycle.
    task automatic host_write(input logic [1:0] r, input logic [15:0] d, input int mode = 0,
                              input logic [AW-1:0] caddr = '0, input logic [15:0] cdat = 16'd0);
        @(negedge clk);
        otg_addr = r; tb_dat = d; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
        cyc(5);
        wr_n = 1'b1;
        if (mode == 1) begin
            cyc(3);
            lif.loc_we = 1'b1; lif.loc_addr = caddr; lif.loc_wdata = cdat;
            cyc(1);
            lif.loc_we = 1'b0;
            m_mem[caddr] = cdat;
        end else if (mode == 2) begin
            cyc(3);
            lif.mbx_in_ack = 1'b1;
            cyc(1);
            lif.mbx_in_ack = 1'b0;
            m_in_vld = 1'b0;
        end else begin
            cyc(4);
        end
        cs_n = 1'b1; tb_oe = 1'b0;
        cyc(3);
        case (r)
            R_DATA: begin
                m_mem[widx(m_addr)] = d;
                if (AUTOINC) m_addr = m_addr + 16'd2;
            end
            R_MBX: begin
                if (m_in_vld) m_ovr = 1'b1;
                m_in_vld = 1'b1;
                m_in_dat = d;
            end
            R_ADDR: m_addr = d;
            default: ;
        endcase
    endtask

    // mid: pulse loc_mbx_wr while the read is still active.
    task automatic host_read(input logic [1:0] r, input string tag, input bit mid = 1'b0,
                             input logic [15:0] midval = 16'd0);
        logic [15:0] exp;
        exp = m_read(r);
        @(negedge clk);
        otg_addr = r; cs_n = 1'b0; rd_n = 1'b0;
        cyc(6);
        check(tag, otg_data, exp);
        if (mid) begin
            lif.loc_mbx_wr = 1'b1; lif.loc_mbx_data = midval;
            cyc(1);
            lif.loc_mbx_wr = 1'b0;
            cyc(1);
        end
        rd_n = 1'b1; cs_n = 1'b1;
        cyc(3);
        check({tag, "_hiz"}, dut.oe_q, 1'b0);
        cyc(1);
        case (r)
            R_DATA:  if (AUTOINC) m_addr = m_addr + 16'd2;
            R_MBX:   m_int = 1'b0;
            R_STAT:  m_ovr = 1'b0;
            default: ;
        endcase
        if (mid) begin
            m_out = midval;
            m_int = 1'b1;
        end
    endtask

    task automatic loc_mem(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        lif.loc_we = 1'b1; lif.loc_addr = a; lif.loc_wdata = d;
        cyc(1);
        lif.loc_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic loc_mbx(input logic [15:0] d);
        @(negedge clk);
        lif.loc_mbx_wr = 1'b1; lif.loc_mbx_data = d;
        cyc(1);
        lif.loc_mbx_wr = 1'b0;
        m_out = d;
        m_int = 1'b1;
        check("int_next", otg_int, 1'b1);
    endtask

    task automatic ack_in();
        @(negedge clk);
        lif.mbx_in_ack = 1'b1;
        cyc(1);
        lif.mbx_in_ack = 1'b0;
        m_in_vld = 1'b0;
    endtask

    int          op;
    logic [1:0]  rr;

    initial begin
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; otg_addr = 2'b00; otg_rst_n = 1'b1;
        tb_oe = 1'b0; tb_dat = 16'd0;
        lif.loc_we = 1'b0; lif.loc_addr = '0; lif.loc_wdata = 16'd0;
        lif.loc_mbx_wr = 1'b0; lif.loc_mbx_data = 16'd0; lif.mbx_in_ack = 1'b0;
        model_reset();
        cyc(6);
        check("rst_hiz", dut.oe_q, 1'b0);
        check_side("rst");
        rst = 1'b0;
        cyc(4);
        for (int i = 0; i < MEM_WORDS; i++) loc_mem(AW'(i), 16'($urandom));
        host_read(R_ADDR, "rst_addr");
        host_read(R_STAT, "rst_stat");

        // ADDRESS / DATA sequence (auto-increment dependent)
        host_write(R_ADDR, 16'h0010);
        host_write(R_DATA, 16'hBEEF);
        host_write(R_DATA, 16'h1234);
        host_write(R_ADDR, 16'h0010);
        host_read(R_DATA, "seq_rd0");
        host_read(R_DATA, "seq_rd1");
        host_read(R_ADDR, "seq_addr");

        // Outbound mailbox and interrupt
        loc_mbx(16'h00A5);
        host_read(R_MBX, "mbx_out");
        check_side("mbx_out");

        // Inbound overrun, sticky bit cleared by STATUS read
        host_write(R_MBX, 16'h0001);
        host_write(R_MBX, 16'h0002);
        check_side("ovr");
        host_read(R_STAT, "ovr_stat0");
        host_read(R_STAT, "ovr_stat1");
        ack_in();
        check_side("ack");

        // Ack coinciding with a host MAILBOX commit
        host_write(R_MBX, 16'h0033);
        host_write(R_MBX, 16'h0044, 2);
        check_side("ack_coll");
        host_read(R_STAT, "ack_coll_stat");
        ack_in();

        // Local outbound load during a MAILBOX read keeps the interrupt
        loc_mbx(16'h0101);
        host_read(R_MBX, "mbx_mid", 1'b1, 16'h0202);
        check_side("mbx_mid");
        host_read(R_MBX, "mbx_mid2");
        check_side("mbx_mid2");

        // Host and local memory writes in the same cycle
        host_write(R_ADDR, 16'h000A);
        host_write(R_DATA, 16'h1111, 1, AW'(5), 16'h2222);
        host_write(R_ADDR, 16'h000A);
        host_read(R_DATA, "coll_same");
        host_write(R_ADDR, 16'h000C);
        host_write(R_DATA, 16'h3333, 1, AW'(7), 16'h4444);
        host_write(R_ADDR, 16'h000C);
        host_read(R_DATA, "coll_w6");
        host_write(R_ADDR, 16'h000E);
        host_read(R_DATA, "coll_w7");

        // Reset in the middle of a DATA write; CS_N held low across release
        host_write(R_ADDR, 16'h0006);
        loc_mbx(16'h0055);
        host_write(R_MBX, 16'h0066);
        @(negedge clk);
        otg_addr = R_DATA; tb_dat = 16'hFFFF; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_reset();
        check("abort_hiz", dut.oe_q, 1'b0);
        check_side("abort");
        cyc(6);
        wr_n = 1'b1;
        cyc(6);
        cs_n = 1'b1; tb_oe = 1'b0;
        cyc(4);
        host_read(R_ADDR, "abort_addr");
        host_read(R_DATA, "abort_w0");
        host_write(R_ADDR, 16'h0006);
        host_read(R_DATA, "abort_w3");

        // Host-driven reset pin
        host_write(R_ADDR, 16'h0020);
        loc_mbx(16'h0077);
        otg_rst_n = 1'b0;
        cyc(5);
        otg_rst_n = 1'b1;
        cyc(4);
        model_reset();
        check_side("otg_rst");
        host_read(R_ADDR, "otg_rst_addr");

        // Randomized mixed traffic
        for (int k = 0; k < 150; k++) begin
            op = int'($urandom_range(0, 6));
            rr = 2'($urandom_range(0, 3));
            case (op)
                0: host_write(rr, 16'($urandom));
                1: host_read(rr, "rnd_rd");
                2: loc_mem(AW'($urandom), 16'($urandom));
                3: loc_mbx(16'($urandom));
                4: ack_in();
                5: host_write(R_ADDR, 16'($urandom));
                default: host_read(R_DATA, "rnd_data");
            endcase
            check_side("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hpi_responder.md
HPI_RESPONDER -- requirements
Module: hpi_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256, sets the number of 16-bit words in the internal memory; it SHALL be a power of 2, from 16 to 4096.
REQ-002 Clk  input  1  system clock; every flop SHALL be clocked on its rising edge.
REQ-003 Reset  input  1  reset; synchronous, active-high.
REQ-004 OTG_DATA  inout  16  HPI data bus; driven only during host reads, otherwise high-Z.
REQ-005 OTG_ADDR  input  2  HPI register select: 00 DATA, 01 MAILBOX, 10 ADDRESS, 11 STATUS.
REQ-006 OTG_CS_N, OTG_RD_N, OTG_WR_N  input  1 each  host chip select and strobes, active-low, asynchronous to Clk.
REQ-007 OTG_RST_N  input  1  host-driven device reset, active-low.
REQ-008 OTG_INT  output  1  interrupt to host; high while the outbound mailbox is full.
REQ-009 loc_we, loc_addr[log2(MEM_WORDS)-1:0], loc_wdata[15:0]  input  local memory write port.
REQ-010 loc_mbx_wr, loc_mbx_data[15:0]  input  local write to the outbound mailbox.
REQ-011 mbx_in_valid  output  1, mbx_in_data  output  16, mbx_in_ack  input  1: inbound mailbox handshake.

Function
REQ-012 CS_N, RD_N, WR_N, ADDR and the DATA input SHALL each pass through 2-flop synchronizers; all decode SHALL use the synchronized copies.
REQ-013 FSM states: IDLE, RD_ACTIVE, WR_ACTIVE, WR_COMMIT.
REQ-014 IDLE -> RD_ACTIVE on sync CS_N=0 & RD_N=0.
REQ-015 In RD_ACTIVE, the block SHALL latch the selected register (DATA = mem[ADDRESS[k:1]]) one cycle after entry and SHALL drive OTG_DATA with it from the second cycle until it leaves RD_ACTIVE.
REQ-016 RD_ACTIVE -> IDLE when sync RD_N=1 or CS_N=1; OTG_DATA SHALL be high-Z within 1 Clk of that exit.
REQ-017 IDLE -> WR_ACTIVE on sync CS_N=0 & WR_N=0.
REQ-018 WR_ACTIVE SHALL capture sync DATA every cycle; on sync WR_N=1 it SHALL go to WR_COMMIT.
REQ-019 WR_COMMIT SHALL write the last captured value to the selected register, then return to IDLE after exactly 1 cycle.
REQ-020 If RD_N and WR_N are both low in IDLE, the write SHALL win.
REQ-021 ADDRESS SHALL be a 16-bit byte address. The word index is ADDRESS[log2(MEM_WORDS):1]; higher bits SHALL be stored but ignored, so indexing wraps modulo MEM_WORDS.
REQ-022 STATUS read: bit0 = outbound mailbox full, bit1 = inbound mailbox full, bit2 = inbound overrun (sticky), other bits 0. A STATUS read SHALL clear bit2 on exit from RD_ACTIVE.
REQ-023 A host write to STATUS SHALL have no effect.
REQ-024 A host MAILBOX write SHALL load mbx_in_data and set mbx_in_valid.
REQ-025 If mbx_in_valid is already 1 at that write, the new data SHALL overwrite the old and overrun SHALL be set.
REQ-026 mbx_in_valid SHALL clear the cycle after mbx_in_ack=1. If a host MAILBOX write commits in the same cycle as the ack, valid SHALL stay 1 with the new data and no overrun.
REQ-027 loc_mbx_wr SHALL load the outbound mailbox and set OTG_INT on the next edge.
REQ-028 A host MAILBOX read SHALL return the outbound value and clear OTG_INT on exit from RD_ACTIVE, unless loc_mbx_wr occurs during the read, in which case OTG_INT SHALL stay 1 with the new value.
REQ-029 When a host DATA commit and loc_we target the same word in the same cycle, the host write SHALL win. Writes to different words SHALL both take effect.
REQ-030 Memory contents SHALL NOT be reset.

Reset
REQ-031 Reset=1 or sync OTG_RST_N=0 SHALL force: FSM IDLE, OTG_DATA high-Z, OTG_INT=0, ADDRESS=0, both mailboxes empty and zero, overrun=0, mbx_in_valid=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no register or memory update.
REQ-033 After Reset releases, the block SHALL wait for sync CS_N=1 before accepting a new transaction.

Configuration
REQ-034 With HPI_RESP_AUTOINC_EN defined, each completed DATA read or write SHALL add 2 to ADDRESS (mod 2^16) on exit from RD_ACTIVE or WR_COMMIT.
REQ-035 With HPI_RESP_AUTOINC_EN undefined, ADDRESS SHALL change only on host ADDRESS writes.

Verification
REQ-036 Write ADDRESS=0x0010, write DATA 0xBEEF, 0x1234 (AUTOINC on), write ADDRESS=0x0010, read DATA twice -> 0xBEEF, 0x1234; ADDRESS reads 0x0014.
REQ-037 Same sequence with AUTOINC off -> both reads 0x1234; ADDRESS reads 0x0010.
REQ-038 loc_mbx_wr 0x00A5 -> OTG_INT=1 next cycle; host MAILBOX read returns 0x00A5; OTG_INT=0 after RD_N rises.
REQ-039 Two host MAILBOX writes 0x0001, 0x0002 with no ack -> mbx_in_data=0x0002, STATUS=0x0006; second STATUS read=0x0002.
REQ-040 Assert Reset during WR_ACTIVE of DATA write 0xFFFF to word 3 -> mem[3] unchanged, ADDRESS=0, OTG_DATA high-Z.
REQ-041 Host DATA write 0x1111 and loc_we 0x2222 commit to word 5 in the same cycle -> mem[5]=0x1111.
